// File: rtl/nonce_search_controller_pkg.sv
// Shared types and constants for the nonce search controller.
package nonce_search_pkg;

  localparam int unsigned NONCE_W          = 32;
  localparam int unsigned CAND_W           = 128;
  localparam int unsigned HASH_W           = 128;
  localparam int unsigned HEADER_W_DEFAULT = CAND_W - NONCE_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic               valid;
    logic [NONCE_W-1:0] nonce;
  } tag_t;

endpackage

// File: rtl/nonce_search_controller_if.sv
// Candidate/result bus between the search controller and the hash core + difficulty filter.
interface nonce_search_controller_if
  import nonce_search_pkg::*;
#(
  parameter int unsigned CW = CAND_W,
  parameter int unsigned HW = HASH_W
);
  logic [CW-1:0] cand_o;
  logic          cand_valid_o;
  logic [HW-1:0] res_i;
  logic          res_valid_i;

  modport master (output cand_o, output cand_valid_o, input res_i, input res_valid_i);
  modport slave  (input cand_o, input cand_valid_o, output res_i, output res_valid_i);
endinterface

// File: rtl/nonce_search_controller_inflight_tag_pipe.sv
// LATENCY-deep {valid, nonce} shift register; the tail lines up with the filter output.
module inflight_tag_pipe
  import nonce_search_pkg::*;
#(
  parameter int unsigned LATENCY = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  tag_t tag_i,
  output tag_t tail_o,
  output logic any_valid_o
);
  tag_t slot_q [LATENCY];

  // Shift every cycle; clear drops all in-flight tags.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      for (int i = 0; i < int'(LATENCY); i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      slot_q[0] <= tag_i;
      for (int i = 1; i < int'(LATENCY); i++) begin
        slot_q[i] <= slot_q[i-1];
      end
    end
  end

  assign tail_o = slot_q[LATENCY-1];

  // High when a valid tag will still be in the pipe after the coming shift.
  always_comb begin
    any_valid_o = tag_i.valid;
    for (int i = 0; i < int'(LATENCY) - 1; i++) begin
      any_valid_o = any_valid_o | slot_q[i].valid;
    end
  end
endmodule

// File: rtl/nonce_search_controller.sv
// Proof-of-work nonce search sequencer; captures the first flagged in-range result.
// Optional NONCE_SEARCH_STATS_EN adds attempts_o, a saturating count of retired valid tags.
module nonce_search_controller
  import nonce_search_pkg::*;
#(
  parameter int unsigned LATENCY  = 2,
  parameter int unsigned HEADER_W = HEADER_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [HEADER_W-1:0]   header_i,
  input  logic [NONCE_W-1:0]    nonce_start_i,
  input  logic [NONCE_W-1:0]    nonce_end_i,
  nonce_search_controller_if.master bus,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  found_o,
  output logic [NONCE_W-1:0]    nonce_o,
  output logic [HASH_W-1:0]     hash_o
`ifdef NONCE_SEARCH_STATS_EN
  ,
  output logic [NONCE_W-1:0]    attempts_o
`endif
);
  localparam int unsigned CW = HEADER_W + NONCE_W;

  state_e             state_q;
  logic [CW-1:0]      cand_q;
  logic               cand_valid_q;
  logic [NONCE_W-1:0] end_q;
  logic               busy_q;
  logic               done_q;
  logic               found_q;
  logic [NONCE_W-1:0] nonce_q;
  logic [HASH_W-1:0]  hash_q;

  tag_t issue_tag;
  tag_t tail;
  logic any_valid;
  logic launch;
  logic match_hit;
  logic last_issue;

  assign launch     = start_i && ((state_q == IDLE) || (state_q == DONE));
  assign match_hit  = bus.res_valid_i && tail.valid && !found_q;
  assign last_issue = (cand_q[NONCE_W-1:0] == end_q);
  assign issue_tag  = '{valid: cand_valid_q, nonce: cand_q[NONCE_W-1:0]};

  inflight_tag_pipe #(.LATENCY(LATENCY)) u_tag_pipe (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (abort_i),
    .tag_i      (issue_tag),
    .tail_o     (tail),
    .any_valid_o(any_valid)
  );

  // Search FSM with all outputs held in registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cand_q       <= '0;
      cand_valid_q <= 1'b0;
      end_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      found_q      <= 1'b0;
      nonce_q      <= '0;
      hash_q       <= '0;
    end else if (abort_i) begin
      state_q      <= IDLE;
      cand_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      found_q      <= 1'b0;
      nonce_q      <= '0;
      hash_q       <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (launch) begin
            found_q <= 1'b0;
            nonce_q <= '0;
            hash_q  <= '0;
            end_q   <= nonce_end_i;
            cand_q  <= {header_i, nonce_start_i};
            if (nonce_end_i >= nonce_start_i) begin
              state_q      <= RUN;
              cand_valid_q <= 1'b1;
              busy_q       <= 1'b1;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (match_hit) begin
            found_q <= 1'b1;
            nonce_q <= tail.nonce;
            hash_q  <= bus.res_i;
          end
          // Stopping at nonce_end before incrementing means the counter never wraps.
          if (match_hit || last_issue) begin
            state_q      <= DRAIN;
            cand_valid_q <= 1'b0;
          end else begin
            cand_q[NONCE_W-1:0] <= cand_q[NONCE_W-1:0] + 32'd1;
          end
        end
        DRAIN: begin
          if (match_hit) begin
            found_q <= 1'b1;
            nonce_q <= tail.nonce;
            hash_q  <= bus.res_i;
          end
          if (!any_valid) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q      <= IDLE;
          cand_valid_q <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cand_o       = cand_q;
  assign bus.cand_valid_o = cand_valid_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign found_o          = found_q;
  assign nonce_o          = nonce_q;
  assign hash_o           = hash_q;

`ifdef NONCE_SEARCH_STATS_EN
  logic [NONCE_W-1:0] attempts_q;

  // Saturating count of valid tags leaving the pipe, matched or not.
  always_ff @(posedge clk) begin
    if (rst || abort_i || launch) begin
      attempts_q <= '0;
    end else if (tail.valid && (attempts_q != 32'hFFFF_FFFF)) begin
      attempts_q <= attempts_q + 32'd1;
    end
  end

  assign attempts_o = attempts_q;
`endif
endmodule

// File: tb/tb_nonce_search_controller.sv
// Directed bench for nonce_search_controller with LATENCY=2.
module tb_nonce_search_controller;
  import nonce_search_pkg::*;

  localparam int unsigned LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        abort_i;
  logic [95:0] header_i;
  logic [31:0] nonce_start_i;
  logic [31:0] nonce_end_i;
  logic        busy_o;
  logic        done_o;
  logic        found_o;
  logic [31:0] nonce_o;
  logic [127:0] hash_o;
`ifdef NONCE_SEARCH_STATS_EN
  logic [31:0] attempts_o;
`endif

  int vectors = 0;
  int miscompares = 0;

  nonce_search_controller_if #(.CW(128), .HW(128)) bus ();

  nonce_search_controller #(.LATENCY(LAT), .HEADER_W(96)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .header_i     (header_i),
    .nonce_start_i(nonce_start_i),
    .nonce_end_i  (nonce_end_i),
    .bus          (bus),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .found_o      (found_o),
    .nonce_o      (nonce_o),
    .hash_o       (hash_o)
`ifdef NONCE_SEARCH_STATS_EN
    ,
    .attempts_o   (attempts_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input string tag, input int j, input bit cv, input logic [31:0] n,
                     input bit bz, input bit dn, input bit fd);
    chk($sformatf("%s.cand_valid@%0d", tag, j), {127'd0, bus.cand_valid_o}, {127'd0, cv});
    if (cv) begin
      chk($sformatf("%s.cand@%0d", tag, j), bus.cand_o, {header_i, n});
    end
    chk($sformatf("%s.busy@%0d", tag, j), {127'd0, busy_o}, {127'd0, bz});
    chk($sformatf("%s.done@%0d", tag, j), {127'd0, done_o}, {127'd0, dn});
    chk($sformatf("%s.found@%0d", tag, j), {127'd0, found_o}, {127'd0, fd});
  endtask

  function automatic logic [127:0] hv(input int j);
    return {96'hC0FFEE_0123_4567_89AB_CDEF, 32'(j)};
  endfunction

  task automatic launch(input logic [31:0] s, input logic [31:0] e);
    nonce_start_i = s;
    nonce_end_i   = e;
    start_i       = 1'b1;
    tick();
    start_i       = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; abort_i = 1'b0;
    header_i = 96'hDEAD_BEEF_0000_1111_2222_3333;
    nonce_start_i = 32'd0; nonce_end_i = 32'd0;
    bus.res_i = 128'd0; bus.res_valid_i = 1'b0;
    tick(); tick();
    chk("rst.cand", bus.cand_o, 128'd0);
    cyc("rst", 0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("rst.nonce", {96'd0, nonce_o}, 128'd0);
    chk("rst.hash", hash_o, 128'd0);
    rst = 1'b0;

    // Filter flag high in IDLE with no valid tags.
    bus.res_valid_i = 1'b1; bus.res_i = hv(99);
    for (int j = 1; j <= 3; j++) begin
      tick();
      cyc("idle_rv", j, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    end
    bus.res_valid_i = 1'b0;

    // Range 0x10-0x1F, filter flags nonce 0x14 (checked at j=7); later flags ignored.
    launch(32'h10, 32'h1F);
    for (int j = 1; j <= 11; j++) begin
      cyc("m14", j, j <= 7, 32'h10 + 32'(j - 1), j <= 9, j == 10, j >= 8);
      bus.res_valid_i = (j >= 7) && (j <= 9);
      bus.res_i = hv(j);
      tick();
    end
    bus.res_valid_i = 1'b0;
    chk("m14.nonce", {96'd0, nonce_o}, {96'd0, 32'h14});
    chk("m14.hash", hash_o, hv(7));

    // Range 0-7, no match: done at T+8+3, still DONE, then flag high in DONE.
    launch(32'h0, 32'h7);
    for (int j = 1; j <= 12; j++) begin
      cyc("nomatch", j, j <= 8, 32'(j - 1), j <= 10, j == 11, 1'b0);
      tick();
    end
`ifdef NONCE_SEARCH_STATS_EN
    chk("nomatch.attempts", {96'd0, attempts_o}, {96'd0, 32'd8});
`endif
    bus.res_valid_i = 1'b1; bus.res_i = hv(98);
    for (int j = 1; j <= 3; j++) begin
      tick();
      cyc("done_rv", j, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    end
    bus.res_valid_i = 1'b0;

    // Range 0x20-0x3F, garbage flags while pipe fills, matches 0x25 (j=8) and 0x26 (j=9).
    launch(32'h20, 32'h3F);
    for (int j = 1; j <= 12; j++) begin
      cyc("m25", j, j <= 8, 32'h20 + 32'(j - 1), j <= 10, j == 11, j >= 9);
      bus.res_valid_i = (j == 1) || (j == 2) || (j == 8) || (j == 9);
      bus.res_i = hv(j + 40);
      tick();
    end
    bus.res_valid_i = 1'b0;
    chk("m25.nonce", {96'd0, nonce_o}, {96'd0, 32'h25});
    chk("m25.hash", hash_o, hv(48));

    // Abort from DONE clears the captured result.
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    cyc("abort_done", 1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("abort_done.nonce", {96'd0, nonce_o}, 128'd0);
    chk("abort_done.hash", hash_o, 128'd0);

    // Abort in the third RUN cycle, then a fresh search matching 0x41 during DRAIN.
    launch(32'h0, 32'hFF);
    for (int j = 1; j <= 3; j++) begin
      cyc("abort_run", j, 1'b1, 32'(j - 1), 1'b1, 1'b0, 1'b0);
      if (j < 3) tick();
    end
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    for (int j = 4; j <= 7; j++) begin
      cyc("abort_run", j, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    launch(32'h40, 32'h41);
    for (int j = 1; j <= 6; j++) begin
      cyc("m41", j, j <= 2, 32'h40 + 32'(j - 1), j <= 4, j == 5, j >= 5);
      bus.res_valid_i = (j == 4);
      bus.res_i = hv(100);
      tick();
    end
    bus.res_valid_i = 1'b0;
    chk("m41.nonce", {96'd0, nonce_o}, {96'd0, 32'h41});
    chk("m41.hash", hash_o, hv(100));

    // Empty range: DONE at T+1, nothing issued.
    launch(32'd5, 32'd3);
    for (int j = 1; j <= 3; j++) begin
      cyc("empty", j, 1'b0, 32'd0, 1'b0, j == 1, 1'b0);
      tick();
    end

    // Reset in the last DRAIN cycle after a match on 0x51.
    launch(32'h50, 32'h52);
    for (int j = 1; j <= 5; j++) begin
      cyc("rstdrain", j, j <= 3, 32'h50 + 32'(j - 1), 1'b1, 1'b0, j >= 5);
      bus.res_valid_i = (j == 4);
      bus.res_i = hv(200);
      if (j < 5) tick();
    end
    bus.res_valid_i = 1'b0;
    chk("rstdrain.nonce_pre", {96'd0, nonce_o}, {96'd0, 32'h51});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cyc("rstdrain", 6, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("rstdrain.cand", bus.cand_o, 128'd0);
    chk("rstdrain.nonce", {96'd0, nonce_o}, 128'd0);
    chk("rstdrain.hash", hash_o, 128'd0);
`ifdef NONCE_SEARCH_STATS_EN
    chk("rstdrain.attempts", {96'd0, attempts_o}, 128'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
